mac_operand_sequencer: RTL
==========================

// Module: mac_operand_sequencer
// PURPOSE
// - Host-side driver for the 4-bit accumulate-every-cycle MAC (a, b, rst, cin -> result, cout).
// - Holds a local buffer of DEPTH operand pairs. On start it clears the MAC, then streams len pairs into it.
// - Captures the final dot product and flags any carry-out seen during the run.
// - Sits between the register/host interface and the MAC datapath.
// PARAMETERS
// - DATA_W  4  operand width (matches MAC a/b)
// - ACC_W   8  accumulator width (matches MAC result)
// - DEPTH   8  operand-pair buffer entries; power of 2
// PORTS
// - clk        in   1              single clock, rising edge
// - rst        in   1              synchronous, active-high reset
// - wr_en      in   1              buffer write strobe
// - wr_addr    in   log2(DEPTH)    buffer entry index
// - wr_a       in   DATA_W         multiplicand to store
// - wr_b       in   DATA_W         multiplier to store
// - start      in   1              launch run (sampled in IDLE only)
// - len        in   log2(DEPTH)+1  pairs to process; values > DEPTH clamp to DEPTH
// - busy       out  1              high in CLR/RUN/CAP
// - done       out  1              one-cycle pulse; dot_out and ovf valid from this cycle
// - dot_out    out  ACC_W          captured MAC result
// - ovf        out  1              1 if MAC cout was seen in any RUN cycle
// - mac_a      out  DATA_W         to MAC a
// - mac_b      out  DATA_W         to MAC b
// - mac_clr    out  1              to MAC rst
// - mac_cin    out  1              to MAC cin; tied 0
// - mac_result in   ACC_W          from MAC result
// - mac_cout   in   1              from MAC cout
// BEHAVIOUR
// - Reset (rst=1 at edge):
//   - state=IDLE, busy=0, done=0, dot_out=0, ovf=0, idx=0.
//   - All buffer entries are set to 0.
//   - mac_clr=1 combinationally while rst is high, so the MAC is cleared too.
//   - Reset wins over every other input, including mid-run; the run is abandoned and no done pulse occurs.
// - mac_a/mac_b: driven from the registered state/idx. Value is buf[idx] in RUN and 0 in every other state.
// - Because the MAC adds every cycle, zero operands keep mac_result stable outside RUN.
// - FSM:
//   - IDLE: start & len!=0 at edge E -> CLR; latch L=min(len,DEPTH); clear ovf_acc.
//   - IDLE: start & len==0 -> stay IDLE; next cycle done=1, dot_out=0, ovf=0.
//   - CLR: mac_clr=1 for exactly one cycle -> RUN with idx=0.
//   - RUN: pair idx is presented; ovf_acc |= mac_cout. idx==L-1 -> CAP, else idx++.
//   - CAP: dot_out<=mac_result, ovf<=ovf_acc, done<=1 -> IDLE.
// - Latency: start sampled at edge E gives done=1 in the cycle after edge E+L+2.
// - Example: L=3 gives done in the cycle after E+5.
// - done is high for exactly one cycle. dot_out/ovf hold their values until the next capture or reset.
// - wr_en while busy=1 is ignored (the buffer is frozen during a run). wr_en in IDLE writes on the edge.
// - Same-edge wr_en and start in IDLE: the write lands first, so the run sees the new data.
// - start while busy=1 is ignored and is not queued.
// - mac_cin is always 0. Arithmetic is modulo 2^ACC_W, as performed by the MAC.
// CONFIGURATION
// - MAC_SAT_EN defined: in CAP, if ovf_acc=1 then dot_out <= {ACC_W{1'b1}}; otherwise dot_out <= mac_result.
// - MAC_SAT_EN undefined: dot_out <= mac_result (wrapped value). ovf reports the carry in both builds.
// TESTING
// - Write (3,5),(2,7),(15,1) to entries 0..2; start with len=3 -> done one cycle after E+5, dot_out=0x2C, ovf=0.
// - Write (15,15) to all 8 entries; len=8:
//   - MAC_SAT_EN undefined -> dot_out=0x08, ovf=1.
//   - MAC_SAT_EN defined -> dot_out=0xFF, ovf=1.
// - len=0 -> done next cycle, dot_out=0, busy never rises. len=12 with DEPTH=8 -> run behaves as len=8.
// - start during RUN, and wr_en to entry 0 during RUN -> neither is accepted.
//   - The next run with unchanged data repeats the previous dot_out.
// - rst pulsed in RUN cycle 2 -> next cycle busy=0, dot_out=0, no done, buffer reads 0.
//   - mac_clr=1 during rst, and mac_result=0 afterwards.
// - Back-to-back: start asserted in the cycle done=1 -> second run accepted and completes correctly.
//   - The stale accumulator is cleared by CLR.

Source files
------------

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer
// Host-side driver for an accumulate-every-cycle MAC. Holds DEPTH operand
// pairs written by the host; on start it clears the MAC for one cycle, then
// streams min(len, DEPTH) pairs into it, and finally captures the MAC result
// and whether any carry-out was seen during the run.
//
// Optional build macro: MAC_SAT_EN -- when defined, a run that saw a carry-out
// captures an all-ones dot_out instead of the wrapped MAC result.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   wr_en/wr_addr     operand buffer write strobe and entry index (IDLE only)
//   wr_a, wr_b        operand pair to store
//   start, len        launch a run of len pairs (len > DEPTH clamps to DEPTH)
//   busy              high while a run is in progress (CLR/RUN/CAP)
//   done              one-cycle pulse when dot_out/ovf are updated
//   dot_out, ovf      captured dot product and carry-seen flag
//   mac_a, mac_b      operands to the MAC (zero outside RUN)
//   mac_clr, mac_cin  MAC clear (also asserted during rst), carry-in (tied 0)
//   mac_result        MAC accumulator value
//   mac_cout          MAC carry-out
module mac_operand_sequencer #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ACC_W  = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]          wr_a,
  input  logic [DATA_W-1:0]          wr_b,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     len,
  output logic                       busy,
  output logic                       done,
  output logic [ACC_W-1:0]           dot_out,
  output logic                       ovf,
  output logic [DATA_W-1:0]          mac_a,
  output logic [DATA_W-1:0]          mac_b,
  output logic                       mac_clr,
  output logic                       mac_cin,
  input  logic [ACC_W-1:0]           mac_result,
  input  logic                       mac_cout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2,
    S_CAP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [AW-1:0]       last_q, last_d;
  logic                ovf_acc_q, ovf_acc_d;
  logic                done_q, done_d;
  logic [ACC_W-1:0]    dot_q, dot_d;
  logic                ovf_q, ovf_d;
  logic [LW-1:0]       len_clamped;

  logic [DATA_W-1:0]   mem_a [DEPTH];
  logic [DATA_W-1:0]   mem_b [DEPTH];

  // Requested length clamped to the buffer size.
  assign len_clamped = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;

  // Operand buffer: cleared on reset, writable only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else if (wr_en && (state_q == S_IDLE)) begin
      mem_a[wr_addr] <= wr_a;
      mem_b[wr_addr] <= wr_b;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      ovf_acc_q <= 1'b0;
      done_q    <= 1'b0;
      dot_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      ovf_acc_q <= ovf_acc_d;
      done_q    <= done_d;
      dot_q     <= dot_d;
      ovf_q     <= ovf_d;
    end
  end

  // Next-state and next-value logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    ovf_acc_d = ovf_acc_q;
    done_d    = 1'b0;
    dot_d     = dot_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_clamped != '0) begin
            state_d   = S_CLR;
            last_d    = AW'(len_clamped - LW'(1));
            ovf_acc_d = 1'b0;
          end else begin
            // Empty run: report a zero result immediately.
            done_d = 1'b1;
            dot_d  = '0;
            ovf_d  = 1'b0;
          end
        end
      end
      S_CLR: begin
        state_d = S_RUN;
        idx_d   = '0;
      end
      S_RUN: begin
        ovf_acc_d = ovf_acc_q | mac_cout;
        if (idx_q == last_q) begin
          state_d = S_CAP;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      S_CAP: begin
`ifdef MAC_SAT_EN
        dot_d = ovf_acc_q ? {ACC_W{1'b1}} : mac_result;
`else
        dot_d = mac_result;
`endif
        ovf_d   = ovf_acc_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // MAC drive: operands only in RUN so the accumulator holds elsewhere.
  assign mac_a   = (state_q == S_RUN) ? mem_a[idx_q] : '0;
  assign mac_b   = (state_q == S_RUN) ? mem_b[idx_q] : '0;
  assign mac_clr = rst | (state_q == S_CLR);
  assign mac_cin = 1'b0;

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign dot_out = dot_q;
  assign ovf     = ovf_q;

endmodule
